// File: rtl/ue14500_seq.sv
// Instruction sequencer for a UE14500-style 1-bit core: fetches 8-bit words,
// strobes the core, and handles JMP/RTN through a small return stack.
module ue14500_seq #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic [3:0]        core_instr,
    output logic [3:0]        core_oper,
    output logic              core_step,
    output logic              halted,
    output logic              err
);

    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_TGT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_ir;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [CNT_W-1:0]  r_cnt;
    logic              r_err;

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_tgt;
    logic [ADDR_W-1:0] w_top;
    logic [PTR_W-1:0]  w_push_idx;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_empty;
    logic              w_full;
    logic [3:0]        w_op;

    assign w_pc_inc   = r_pc + ADDR_W'(1);
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == CNT_W'(STACK_DEPTH));
    assign w_push_idx = PTR_W'(r_cnt);
    assign w_top_idx  = PTR_W'(r_cnt - CNT_W'(1));
    assign w_top      = r_stack[w_top_idx];
    assign w_op       = r_ir[7:4];

    // Jump targets are a full data word, zero-extended for wide address spaces.
    if (ADDR_W > 8) begin : g_tgt_wide
        assign w_tgt = {{(ADDR_W - 8){1'b0}}, mem_data};
    end else begin : g_tgt_narrow
        assign w_tgt = mem_data[ADDR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HALT;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        mem_rd     = 1'b0;
        core_step  = 1'b0;
        core_instr = 4'h0;
        core_oper  = 4'h0;
        case (r_state)
            S_HALT: begin
                if (run) w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ack) w_next = S_EXEC;
            end
            S_EXEC: begin
                core_step  = 1'b1;
                core_instr = r_ir[7:4];
                core_oper  = r_ir[3:0];
                case (w_op)
                    OP_JMP:  w_next = S_TGT;
                    OP_RTN:  w_next = w_empty ? S_HALT : S_FETCH;
                    OP_NOPF: w_next = S_HALT;
                    default: w_next = S_FETCH;
                endcase
            end
            S_TGT: begin
                mem_rd = 1'b1;
                if (mem_ack) w_next = w_full ? S_HALT : S_FETCH;
            end
            default: w_next = S_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= '0;
            r_ir  <= 8'h00;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_HALT: begin
                    if (run) r_err <= 1'b0;
                end
                S_FETCH: begin
                    if (mem_ack) r_ir <= mem_data;
                end
                S_EXEC: begin
                    r_pc <= w_pc_inc;
                    if (w_op == OP_RTN) begin
                        if (w_empty) begin
                            r_err <= 1'b1;
                        end else begin
                            r_pc  <= w_top;
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end
                S_TGT: begin
                    if (mem_ack) begin
                        if (w_full) begin
                            r_err <= 1'b1;
                        end else begin
                            r_pc  <= w_tgt;
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the stack array has no reset; the count alone decides validity,
    // which keeps this a plain register file without a reset network.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_TGT && mem_ack && !w_full)
            r_stack[w_push_idx] <= w_pc_inc;
    end

    assign mem_addr = r_pc;
    assign halted   = (r_state == S_HALT);
    assign err      = r_err;

endmodule

// File: tb/tb_ue14500_seq.sv
// Self-checking bench for ue14500_seq: cycle table for straight-line code,
// directed sequences for wait states, jumps, stack errors and reset aborts.
module tb_ue14500_seq;

    logic       clk;
    logic       rst;
    logic       run;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [3:0] core_instr;
    logic [3:0] core_oper;
    logic       core_step;
    logic       halted;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    int         ack_delay;
    logic       ack_en;
    int         wait_cnt;
    logic [7:0] fetch_log [$];

    ue14500_seq #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .core_instr (core_instr),
        .core_oper  (core_oper),
        .core_step  (core_step),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acknowledges after ack_delay wait cycles of a held request.
    assign mem_data = mem[mem_addr];
    assign mem_ack  = mem_rd && ack_en && (wait_cnt >= ack_delay);

    always @(posedge clk) begin
        if (!mem_rd || mem_ack) wait_cnt <= 0;
        else                    wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_rd && mem_ack) fetch_log.push_back(mem_addr);
    end

    typedef struct {
        logic       run;
        logic       err;
        logic       halted;
        logic       rd;
        logic       step;
        logic [3:0] instr;
        logic [3:0] oper;
        logic [7:0] addr;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nopf();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        run       = 1'b0;
        ack_en    = 1'b1;
        ack_delay = 0;
        tick();
        tick();
        rst = 1'b0;
        fetch_log.delete();
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 200) begin
            tick();
            n++;
        end
        check(name, halted, 1);
    endtask

    function automatic logic [31:0] pack_out(input logic e, input logic h, input logic r,
                                             input logic s, input logic [3:0] ins,
                                             input logic [3:0] op, input logic [7:0] a);
        return {12'h0, e, h, r, s, ins, op, a};
    endfunction

    logic [7:0] exp_fetch [9];
    int rd_cycles, ack_at, step_at, n;
    logic step_rd;

    initial begin
        vecs[0] = '{run:1'b1, err:1'b0, halted:1'b1, rd:1'b0, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h00};
        vecs[1] = '{run:1'b1, err:1'b0, halted:1'b0, rd:1'b1, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h00};
        vecs[2] = '{run:1'b0, err:1'b0, halted:1'b0, rd:1'b0, step:1'b1, instr:4'h4, oper:4'h1, addr:8'h00};
        vecs[3] = '{run:1'b1, err:1'b0, halted:1'b0, rd:1'b1, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h01};
        vecs[4] = '{run:1'b0, err:1'b0, halted:1'b0, rd:1'b0, step:1'b1, instr:4'h1, oper:4'h2, addr:8'h01};
        vecs[5] = '{run:1'b0, err:1'b0, halted:1'b0, rd:1'b1, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h02};
        vecs[6] = '{run:1'b0, err:1'b0, halted:1'b0, rd:1'b0, step:1'b1, instr:4'hF, oper:4'h0, addr:8'h02};
        vecs[7] = '{run:1'b0, err:1'b0, halted:1'b1, rd:1'b0, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h03};
        vecs[8] = '{run:1'b0, err:1'b0, halted:1'b1, rd:1'b0, step:1'b0, instr:4'h0, oper:4'h0, addr:8'h03};

        // Straight-line program, zero-wait memory, stepped cycle by cycle.
        rst = 1'b1;
        run = 1'b0;
        fill_nopf();
        mem[0] = 8'h41;
        mem[1] = 8'h12;
        mem[2] = 8'hF0;
        do_reset();
        check("reset_state", pack_out(err, halted, mem_rd, core_step, core_instr, core_oper, mem_addr),
              pack_out(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00));
        for (int i = 0; i < 9; i++) begin
            check($sformatf("prog_row%0d", i),
                  pack_out(err, halted, mem_rd, core_step, core_instr, core_oper, mem_addr),
                  pack_out(vecs[i].err, vecs[i].halted, vecs[i].rd, vecs[i].step,
                           vecs[i].instr, vecs[i].oper, vecs[i].addr));
            run = vecs[i].run;
            tick();
        end
        run = 1'b0;

        // Three wait cycles on the first fetch.
        fill_nopf();
        mem[0] = 8'h41;
        do_reset();
        ack_delay = 3;
        pulse_run();
        rd_cycles = 0;
        ack_at    = -1;
        step_at   = -1;
        step_rd   = 1'b1;
        for (int c = 0; c < 20 && step_at < 0; c++) begin
            if (mem_rd)  rd_cycles++;
            if (mem_ack) ack_at = c;
            if (core_step) begin
                step_at = c;
                step_rd = mem_rd;
            end
            tick();
        end
        check("wait_rd_cycles", rd_cycles, 4);
        check("wait_ack_at", ack_at, 3);
        check("wait_step_at", step_at, 4);
        check("wait_rd_low_on_step", step_rd, 0);
        ack_delay = 0;
        wait_halt("wait_halt");

        // JMP to a subroutine that returns.
        fill_nopf();
        for (int i = 0; i < 5; i++) mem[i] = 8'h00;
        mem[5]     = 8'hC0;
        mem[6]     = 8'h40;
        mem[8'h40] = 8'hD0;
        do_reset();
        pulse_run();
        wait_halt("jmp_halt");
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h40, 8'h07};
        check("jmp_fetch_count", fetch_log.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < fetch_log.size()) check($sformatf("jmp_fetch%0d", i), fetch_log[i], exp_fetch[i]);
        check("jmp_err", err, 0);
        check("jmp_pc", mem_addr, 8'h08);

        // Five nested JMPs overflow a four-entry stack.
        fill_nopf();
        for (int k = 0; k < 5; k++) begin
            mem[k * 16]     = 8'hC0;
            mem[k * 16 + 1] = 8'((k + 1) * 16);
        end
        mem[8'h41] = 8'h50;
        do_reset();
        pulse_run();
        wait_halt("ovf_halt");
        check("ovf_err", err, 1);
        check("ovf_pc", mem_addr, 8'h41);
        pulse_run();
        check("ovf_run_clears_err", err, 0);
        check("ovf_run_fetch", {mem_rd, mem_addr}, {1'b1, 8'h41});
        wait_halt("ovf_rehalt");

        // RTN with an empty stack.
        fill_nopf();
        mem[0] = 8'hD0;
        do_reset();
        pulse_run();
        wait_halt("udf_halt");
        check("udf_err_pc", {err, mem_addr}, {1'b1, 8'h01});

        // Reset while waiting on the jump-target read; the late ack is dropped.
        fill_nopf();
        mem[0] = 8'hC0;
        mem[1] = 8'h05;
        do_reset();
        pulse_run();
        n = 0;
        while (!core_step && n < 10) begin
            tick();
            n++;
        end
        check("abort_jmp_step", core_step, 1);
        ack_en = 1'b0;
        tick();
        check("abort_tgt_wait", {mem_rd, mem_addr}, {1'b1, 8'h01});
        tick();
        tick();
        rst    = 1'b1;
        ack_en = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_after_rst", pack_out(err, halted, mem_rd, core_step, core_instr, core_oper, mem_addr),
              pack_out(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00));
        tick();
        check("abort_stays_halted", {halted, mem_ack, mem_addr}, {1'b1, 1'b0, 8'h00});
        mem[0] = 8'hD0;
        pulse_run();
        wait_halt("abort_rtn_halt");
        check("abort_stack_empty", {err, mem_addr}, {1'b1, 8'h01});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ue14500_seq.md
UE14500_SEQ -- requirements
Module: ue14500_seq

Interface
- REQ-001: Parameter ADDR_W, default 8, program address width.
- REQ-002: Parameter STACK_DEPTH, default 4, return-stack entries.
- REQ-003: clk  input  1  single clock; all state changes on rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: run  input  1  one-cycle start/resume pulse.
- REQ-006: mem_addr  output  ADDR_W  program memory address.
- REQ-007: mem_rd  output  1  read request, held until acknowledged.
- REQ-008: mem_ack  input  1  read data valid this cycle.
- REQ-009: mem_data  input  8  instruction word: [7:4] opcode, [3:0] operand; a full word when it is a jump target.
- REQ-010: core_instr  output  4  opcode presented to the 1-bit core.
- REQ-011: core_oper  output  4  operand (I/O select) presented to the core.
- REQ-012: core_step  output  1  one-cycle strobe; the core executes core_instr on it.
- REQ-013: halted  output  1  high while in HALT.
- REQ-014: err  output  1  sticky stack error.

Function
- REQ-015: FSM states are HALT, FETCH, EXEC and TGT; PC is ADDR_W bits; the return stack holds STACK_DEPTH entries of ADDR_W bits, with a count register.
- REQ-016: HALT: mem_rd=0, core_step=0, halted=1; a run pulse clears err and moves to FETCH with PC unchanged.
- REQ-017: FETCH: mem_rd=1, mem_addr=PC; on mem_ack=1 the sequencer latches mem_data and goes to EXEC; with no ack it stays indefinitely.
- REQ-018: EXEC lasts exactly one cycle: core_step=1, core_instr=latched[7:4], core_oper=latched[3:0], PC<=PC+1 with wrap from all-ones to 0.
- REQ-019: Opcodes 0000-1011 and 1110 (SKZ): EXEC->FETCH; skip handling is internal to the core.
- REQ-020: JMP (1100): EXEC->TGT; TGT reads mem_addr=PC, which is the word after the JMP, with the same handshake as FETCH.
- REQ-021: On the TGT ack:
  - push (PC+1) mod 2^ADDR_W;
  - PC<=mem_data[ADDR_W-1:0], zero-extended when ADDR_W>8;
  - go to FETCH.
- REQ-022: RTN (1101), stack not empty: PC<=top entry, pop, go to FETCH.
- REQ-023: RTN with an empty stack (underflow): err<=1, go to HALT, PC stays at the value already incremented in EXEC.
- REQ-024: JMP with a full stack (overflow): err<=1, no push, no PC load, go to HALT from TGT after the ack; PC holds the target-word address.
- REQ-025: NOPF (1111): the core still gets core_step; the sequencer then goes to HALT, and PC points at the next word.
- REQ-026: Fetch latency: mem_rd rising to core_step is (ack wait + 1) cycles; with zero-wait memory, one instruction takes 2 cycles and JMP takes 3.
- REQ-027: mem_ack outside FETCH/TGT is ignored; run outside HALT is ignored.
- REQ-028: core_step is never high in two consecutive cycles.
- REQ-029: mem_rd falls in the cycle after the accepting ack.

Reset
- REQ-030: While rst=1 at a clock edge: state=HALT, PC=0, stack count=0, err=0, mem_rd=0, core_step=0, core_instr=0, core_oper=0, halted=1, mem_addr=0.
- REQ-031: rst has priority over run, mem_ack and any in-progress fetch; a fetch aborted by reset is never completed and a late mem_ack is ignored.
- REQ-032: Stack contents need not be cleared; only the count resets.

Verification
- REQ-033: Reset, run, zero-wait memory holding 0x41,0x12,0xF0 at 0..2 -> core_step pulses carry (4,1),(1,2),(F,0) every 2nd cycle; then halted=1 and PC=3.
- REQ-034: mem_ack delayed 3 cycles on address 0 -> mem_rd stays high 4 cycles and core_step fires the cycle after ack.
- REQ-035: JMP at 0x05 with target word 0x40, and RTN at 0x40 -> fetches 0x05,0x06,0x40,0x07; no err.
- REQ-036: Five nested JMPs with STACK_DEPTH=4 -> fifth JMP sets err=1 and halts, PC=target-word address; run clears err.
- REQ-037: RTN after reset with an empty stack -> err=1, halted=1, PC=1.
- REQ-038: Assert rst during a TGT wait, then ack arrives -> no push, PC=0, state HALT.
